mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU instruction-fetch port (IM_*) and data-memory port (DM_*).
- Registers each granted request and holds it stable on the MEM_* bus until MEM_ack.
- Returns read data to the owning requester and raises a pipeline stall while any enabled request is unserved.
- Grants DM priority over IM, with an anti-starvation limit for IM.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, max consecutive DM grants made while IM is pending before IM is forced through; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- IM_en  in  1  instruction fetch request; held until IM_ready.
- IM_address  in  ADDR_W  fetch address.
- IM_out  out  DATA_W  fetched word; valid when IM_ready=1.
- IM_ready  out  1  one-cycle completion pulse for IM.
- DM_en  in  1  data request; held until DM_ready.
- DM_write  in  1  1 = store, 0 = load.
- DM_address  in  ADDR_W  data address.
- DM_in  in  DATA_W  store data.
- DM_out  out  DATA_W  load data; valid when DM_ready=1.
- DM_ready  out  1  one-cycle completion pulse for DM.
- stall  out  1  pipeline hold request.
- MEM_req  out  1  memory request; held until MEM_ack.
- MEM_write  out  1  memory write strobe.
- MEM_addr  out  ADDR_W  memory address.
- MEM_wdata  out  DATA_W  memory write data.
- MEM_rdata  in  DATA_W  memory read data; sampled on MEM_ack.
- MEM_ack  in  1  memory completion; valid only while MEM_req=1.

Behaviour:
- Reset:
  - State = IDLE; dm_streak = 0.
  - All registered outputs are 0: MEM_req, MEM_write, MEM_addr, MEM_wdata, IM_out, DM_out, IM_ready, DM_ready.
  - Reset during an outstanding transaction abandons it: MEM_req is 0 in the cycle after rst is sampled, and no ready pulse is issued.
- FSM states: IDLE, IM_BUSY, DM_BUSY.
- IDLE, candidate selection:
  - IM is a candidate if IM_en=1 and IM_ready=0 this cycle.
  - DM is a candidate if DM_en=1 and DM_ready=0 this cycle.
  - The ready=0 condition blocks re-issue on the completion cycle.
- IDLE, grant rules:
  - Both candidates and dm_streak < STARVE_LIMIT: grant DM.
  - Both candidates and dm_streak == STARVE_LIMIT: grant IM.
  - One candidate: grant it.
  - None: stay in IDLE.
- Grant actions:
  - Go to the matching BUSY state.
  - Register MEM_req=1, MEM_addr, MEM_write (DM_write for DM, 0 for IM) and MEM_wdata (DM_in for DM, 0 for IM).
  - MEM_req is therefore first high one cycle after the request is seen.
- dm_streak:
  - +1 on a DM grant while IM_en=1, saturating at STARVE_LIMIT.
  - Cleared on any IM grant, and on a DM grant with IM_en=0.
- BUSY:
  - MEM_req, MEM_addr, MEM_write and MEM_wdata are held constant until MEM_ack=1.
  - Requester inputs are ignored while BUSY; a requester that drops en mid-transaction still gets its ready pulse.
- On MEM_ack=1 in BUSY:
  - Next cycle: MEM_req=0, MEM_write=0, state = IDLE.
  - The owning ready output is 1 for exactly that one cycle.
  - For an IM read or a DM load, the owner's _out register takes MEM_rdata.
  - For a DM store, DM_out is unchanged.
- Latency:
  - A request seen in IDLE at cycle t with ack at cycle t+k (k >= 1) gives ready at t+k+1.
  - Minimum is 2 cycles, for ack in the first MEM_req cycle.
  - The next grant can issue in the ready cycle (other requester only), so MEM_req can be high again at t+k+2.
- Output hold: IM_out and DM_out hold their last value between transactions.
- stall = (IM_en & ~IM_ready) | (DM_en & ~DM_ready). This is the only combinational output.
- MEM_ack outside BUSY is ignored.

Test Plan:
- Single IM read: IM_en=1, IM_address=0x100, ack 3 cycles after MEM_req rises, MEM_rdata=0xDEADBEEF.
  - Expect MEM_addr=0x100 and MEM_write=0, held stable.
  - Expect IM_ready pulse 1 cycle after ack with IM_out=0xDEADBEEF.
  - Expect stall=1 from request through the cycle before IM_ready.
- Simultaneous IM/DM: IM 0x200 and DM load 0x1000 both raised in the same cycle, immediate acks.
  - Expect the DM transaction first, then IM.
  - Expect MEM_req to rise again on the cycle after DM_ready.
  - Expect dm_streak=1 after the DM grant.
- DM store: DM_write=1, DM_address=0x40, DM_in=0x12345678.
  - Expect MEM_write=1 and MEM_wdata=0x12345678 until ack.
  - Expect DM_ready pulse with DM_out unchanged.
- Starvation: IM_en held high while DM issues 6 back-to-back loads, STARVE_LIMIT=4.
  - Expect grant order DM,DM,DM,DM,IM,DM,DM.
  - Expect dm_streak to clear on the IM grant.
- Reset mid-transaction: assert rst while in DM_BUSY before ack.
  - Expect MEM_req=0 and all outputs 0 the next cycle.
  - Expect no DM_ready pulse, including if a late MEM_ack=1 arrives after reset.
- Hold check: IM in BUSY with ack delayed 10 cycles, while IM_address changes and DM_en is raised.
  - Expect MEM_addr unchanged throughout.
  - Expect DM granted only after IM_ready.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, variable-latency memory between the instruction
// fetch port (IM_*) and the data port (DM_*). A granted request is
// registered onto the MEM_* bus and held there until MEM_ack. Read data goes
// back to the requester that owns the transaction, together with a
// one-cycle ready pulse. DM has priority over IM. After STARVE_LIMIT
// consecutive DM grants made while IM_en is high, IM is forced through.
//
// Handshake rules:
//   A requester raises *_en and holds it until its *_ready pulse.
//   MEM_req/MEM_addr/MEM_write/MEM_wdata stay constant from the grant until
//   the cycle MEM_ack is sampled high. The owner's ready pulse comes one
//   cycle after that. MEM_ack is ignored unless a transaction is in flight.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   IM_en/IM_address -> IM_out/IM_ready            fetch port
//   DM_en/DM_write/DM_address/DM_in -> DM_out/DM_ready   data port
//   stall                           combinational pipeline hold request
//   MEM_req/MEM_write/MEM_addr/MEM_wdata, MEM_rdata/MEM_ack   memory bus
//   dbg_state_o, dbg_dm_streak_o    FSM state and DM streak, for observation
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_en,
  input  logic [ADDR_W-1:0] IM_address,
  output logic [DATA_W-1:0] IM_out,
  output logic              IM_ready,
  input  logic              DM_en,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              DM_ready,
  output logic              stall,
  output logic              MEM_req,
  output logic              MEM_write,
  output logic [ADDR_W-1:0] MEM_addr,
  output logic [DATA_W-1:0] MEM_wdata,
  input  logic [DATA_W-1:0] MEM_rdata,
  input  logic              MEM_ack,
  output logic [1:0]        dbg_state_o,
  output logic [SW-1:0]     dbg_dm_streak_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IM_BUSY = 2'd1;
  localparam logic [1:0] DM_BUSY = 2'd2;

  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] im_out_q, im_out_d;
  logic [DATA_W-1:0] dm_out_q, dm_out_d;
  logic              im_ready_q, im_ready_d;
  logic              dm_ready_q, dm_ready_d;

  // A requester whose ready pulse is showing this cycle is not a candidate,
  // so a still-high en on the completion cycle does not re-issue.
  logic im_cand, dm_cand;
  assign im_cand = IM_en & ~im_ready_q;
  assign dm_cand = DM_en & ~dm_ready_q;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    req_d      = req_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    im_out_d   = im_out_q;
    dm_out_d   = dm_out_q;
    im_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_cand && (!im_cand || streak_q < STREAK_MAX)) begin
          state_d = DM_BUSY;
          req_d   = 1'b1;
          write_d = DM_write;
          addr_d  = DM_address;
          wdata_d = DM_in;
          // The streak only grows while IM is waiting; it saturates.
          if (IM_en) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (im_cand) begin
          state_d  = IM_BUSY;
          req_d    = 1'b1;
          write_d  = 1'b0;
          addr_d   = IM_address;
          wdata_d  = '0;
          streak_d = '0;
        end
      end
      IM_BUSY: begin
        if (MEM_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          write_d    = 1'b0;
          im_out_d   = MEM_rdata;
          im_ready_d = 1'b1;
        end
      end
      DM_BUSY: begin
        if (MEM_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          write_d    = 1'b0;
          // A store returns no data; DM_out keeps the last load value.
          if (!write_q) dm_out_d = MEM_rdata;
          dm_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      req_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      im_out_q   <= '0;
      dm_out_q   <= '0;
      im_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      req_q      <= req_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      im_out_q   <= im_out_d;
      dm_out_q   <= dm_out_d;
      im_ready_q <= im_ready_d;
      dm_ready_q <= dm_ready_d;
    end
  end

  assign MEM_req         = req_q;
  assign MEM_write       = write_q;
  assign MEM_addr        = addr_q;
  assign MEM_wdata       = wdata_q;
  assign IM_out          = im_out_q;
  assign DM_out          = dm_out_q;
  assign IM_ready        = im_ready_q;
  assign DM_ready        = dm_ready_q;
  assign stall           = (IM_en & ~im_ready_q) | (DM_en & ~dm_ready_q);
  assign dbg_state_o     = state_q;
  assign dbg_dm_streak_o = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 time unit after a
// rising edge; registered outputs are sampled there too, and stall is
// sampled after a further unit so it reflects the freshly driven inputs.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IM   = 2'd1;
  localparam logic [1:0] S_DM   = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              IM_en;
  logic [ADDR_W-1:0] IM_address;
  logic [DATA_W-1:0] IM_out;
  logic              IM_ready;
  logic              DM_en;
  logic              DM_write;
  logic [ADDR_W-1:0] DM_address;
  logic [DATA_W-1:0] DM_in;
  logic [DATA_W-1:0] DM_out;
  logic              DM_ready;
  logic              stall;
  logic              MEM_req;
  logic              MEM_write;
  logic [ADDR_W-1:0] MEM_addr;
  logic [DATA_W-1:0] MEM_wdata;
  logic [DATA_W-1:0] MEM_rdata;
  logic              MEM_ack;
  logic [1:0]        dbg_state;
  logic [2:0]        dbg_streak;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .IM_en(IM_en), .IM_address(IM_address), .IM_out(IM_out), .IM_ready(IM_ready),
    .DM_en(DM_en), .DM_write(DM_write), .DM_address(DM_address), .DM_in(DM_in),
    .DM_out(DM_out), .DM_ready(DM_ready), .stall(stall),
    .MEM_req(MEM_req), .MEM_write(MEM_write), .MEM_addr(MEM_addr),
    .MEM_wdata(MEM_wdata), .MEM_rdata(MEM_rdata), .MEM_ack(MEM_ack),
    .dbg_state_o(dbg_state), .dbg_dm_streak_o(dbg_streak)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; IM_en = 1'b0; IM_address = '0; DM_en = 1'b0; DM_write = 1'b0;
    DM_address = '0; DM_in = '0; MEM_rdata = '0; MEM_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (MEM_req !== 1'b0 || MEM_write !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: req=%0b write=%0b expected 0 0", MEM_req, MEM_write); end
    checks++; if (MEM_addr !== 32'h0 || MEM_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0 0", MEM_addr, MEM_wdata); end
    checks++; if (IM_out !== 32'h0 || DM_out !== 32'h0) begin errors++; $display("FAIL reset_outs: im_out=%h dm_out=%h expected 0 0", IM_out, DM_out); end
    checks++; if (IM_ready !== 1'b0 || DM_ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_flags: im_rdy=%0b dm_rdy=%0b stall=%0b expected 0", IM_ready, DM_ready, stall); end
    checks++; if (dbg_state !== S_IDLE || dbg_streak !== 3'd0) begin errors++; $display("FAIL reset_state: state=%0d streak=%0d expected 0 0", dbg_state, dbg_streak); end
  endtask

  task automatic test_im_read();
    IM_en = 1'b1; IM_address = 32'h100;
    #1;
    checks++; if (stall !== 1'b1 || MEM_req !== 1'b0) begin errors++; $display("FAIL im_request: stall=%0b req=%0b expected 1 0", stall, MEM_req); end
    tick();
    checks++; if (MEM_req !== 1'b1 || MEM_addr !== 32'h100 || MEM_write !== 1'b0) begin errors++; $display("FAIL im_grant: req=%0b addr=%h write=%0b expected 1 100 0", MEM_req, MEM_addr, MEM_write); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (MEM_req !== 1'b1 || MEM_addr !== 32'h100 || IM_ready !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL im_wait%0d: req=%0b addr=%h rdy=%0b stall=%0b expected 1 100 0 1", i, MEM_req, MEM_addr, IM_ready, stall); end
    end
    MEM_ack = 1'b1; MEM_rdata = 32'hDEADBEEF;
    tick();
    MEM_ack = 1'b0; MEM_rdata = 32'h0;
    #1;
    checks++; if (IM_ready !== 1'b1 || IM_out !== 32'hDEADBEEF || MEM_req !== 1'b0) begin errors++; $display("FAIL im_done: rdy=%0b out=%h req=%0b expected 1 deadbeef 0", IM_ready, IM_out, MEM_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL im_done_stall: got %0b expected 0", stall); end
    // IM_en still high across the ready cycle: must not re-issue.
    tick();
    checks++; if (MEM_req !== 1'b0 || IM_ready !== 1'b0 || IM_out !== 32'hDEADBEEF) begin errors++; $display("FAIL im_no_reissue: req=%0b rdy=%0b out=%h expected 0 0 deadbeef", MEM_req, IM_ready, IM_out); end
    IM_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    IM_en = 1'b1; IM_address = 32'h200;
    DM_en = 1'b1; DM_write = 1'b0; DM_address = 32'h1000;
    tick();
    checks++; if (dbg_state !== S_DM || MEM_addr !== 32'h1000 || MEM_write !== 1'b0) begin errors++; $display("FAIL sim_dm_first: state=%0d addr=%h write=%0b expected 2 1000 0", dbg_state, MEM_addr, MEM_write); end
    checks++; if (dbg_streak !== 3'd1) begin errors++; $display("FAIL sim_streak1: got %0d expected 1", dbg_streak); end
    MEM_ack = 1'b1; MEM_rdata = 32'hA5A50001;
    tick();
    MEM_ack = 1'b0; DM_en = 1'b0;
    #1;
    checks++; if (DM_ready !== 1'b1 || DM_out !== 32'hA5A50001 || MEM_req !== 1'b0) begin errors++; $display("FAIL sim_dm_done: rdy=%0b out=%h req=%0b expected 1 a5a50001 0", DM_ready, DM_out, MEM_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sim_stall_im: got %0b expected 1", stall); end
    tick();
    checks++; if (MEM_req !== 1'b1 || dbg_state !== S_IM || MEM_addr !== 32'h200 || DM_ready !== 1'b0) begin errors++; $display("FAIL sim_im_next: req=%0b state=%0d addr=%h dmrdy=%0b expected 1 1 200 0", MEM_req, dbg_state, MEM_addr, DM_ready); end
    checks++; if (dbg_streak !== 3'd0) begin errors++; $display("FAIL sim_streak0: got %0d expected 0", dbg_streak); end
    MEM_ack = 1'b1; MEM_rdata = 32'h0BADF00D;
    tick();
    MEM_ack = 1'b0; IM_en = 1'b0;
    checks++; if (IM_ready !== 1'b1 || IM_out !== 32'h0BADF00D || DM_out !== 32'hA5A50001) begin errors++; $display("FAIL sim_im_done: rdy=%0b im_out=%h dm_out=%h expected 1 0badf00d a5a50001", IM_ready, IM_out, DM_out); end
    tick();
  endtask

  task automatic test_dm_store();
    DM_en = 1'b1; DM_write = 1'b1; DM_address = 32'h40; DM_in = 32'h12345678;
    tick();
    DM_in = 32'hCAFEF00D; DM_address = 32'h44;   // ignored while busy
    for (int i = 0; i < 2; i++) begin
      checks++; if (MEM_req !== 1'b1 || MEM_write !== 1'b1 || MEM_wdata !== 32'h12345678 || MEM_addr !== 32'h40) begin errors++; $display("FAIL st_hold%0d: req=%0b wr=%0b wdata=%h addr=%h expected 1 1 12345678 40", i, MEM_req, MEM_write, MEM_wdata, MEM_addr); end
      tick();
    end
    MEM_ack = 1'b1; MEM_rdata = 32'hFFFFFFFF;
    tick();
    MEM_ack = 1'b0; DM_en = 1'b0; DM_write = 1'b0;
    checks++; if (DM_ready !== 1'b1 || DM_out !== 32'hA5A50001 || MEM_write !== 1'b0 || MEM_req !== 1'b0) begin errors++; $display("FAIL st_done: rdy=%0b out=%h wr=%0b req=%0b expected 1 a5a50001 0 0", DM_ready, DM_out, MEM_write, MEM_req); end
    tick();
    checks++; if (DM_ready !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL st_pulse_width: rdy=%0b state=%0d expected 0 0", DM_ready, dbg_state); end
  endtask

  // Each round raises both requests in an idle cycle. The loser withdraws
  // during the transaction so the winner's ready cycle does not hand the bus
  // to it, which lets consecutive DM grants build up the streak.
  task automatic test_starvation();
    logic       exp_dm;
    logic [2:0] exp_streak;
    exp_streak = 3'd0;
    for (int r = 0; r < 7; r++) begin
      IM_en = 1'b1; IM_address = 32'h300;
      DM_en = 1'b1; DM_write = 1'b0; DM_address = 32'h2000 + 32'(r * 4);
      exp_dm     = (r != 4);
      exp_streak = exp_dm ? exp_streak + 3'd1 : 3'd0;
      tick();
      if (exp_dm) IM_en = 1'b0; else DM_en = 1'b0;
      checks++; if (dbg_state !== (exp_dm ? S_DM : S_IM) || MEM_addr !== (exp_dm ? 32'h2000 + 32'(r * 4) : 32'h300)) begin errors++; $display("FAIL starve_grant%0d: state=%0d addr=%h expected dm=%0b", r, dbg_state, MEM_addr, exp_dm); end
      checks++; if (dbg_streak !== exp_streak) begin errors++; $display("FAIL starve_streak%0d: got %0d expected %0d", r, dbg_streak, exp_streak); end
      MEM_ack = 1'b1; MEM_rdata = 32'h5000 + 32'(r);
      tick();
      MEM_ack = 1'b0; IM_en = 1'b0; DM_en = 1'b0;
      checks++; if (IM_ready !== !exp_dm || DM_ready !== exp_dm) begin errors++; $display("FAIL starve_ready%0d: im=%0b dm=%0b expected dm=%0b", r, IM_ready, DM_ready, exp_dm); end
      tick();
    end
    checks++; if (IM_out !== 32'h5004 || DM_out !== 32'h5006) begin errors++; $display("FAIL starve_data: im_out=%h dm_out=%h expected 5004 5006", IM_out, DM_out); end
  endtask

  task automatic test_hold();
    IM_en = 1'b1; IM_address = 32'h500;
    tick();
    for (int i = 0; i < 10; i++) begin
      IM_address = 32'h600 + 32'(i);
      DM_en = 1'b1; DM_write = 1'b0; DM_address = 32'h3000;
      checks++; if (MEM_addr !== 32'h500 || dbg_state !== S_IM || MEM_req !== 1'b1 || DM_ready !== 1'b0) begin errors++; $display("FAIL hold%0d: addr=%h state=%0d req=%0b dmrdy=%0b expected 500 1 1 0", i, MEM_addr, dbg_state, MEM_req, DM_ready); end
      tick();
    end
    MEM_ack = 1'b1; MEM_rdata = 32'h55AA55AA;
    tick();
    MEM_ack = 1'b0; IM_en = 1'b0;
    checks++; if (IM_ready !== 1'b1 || IM_out !== 32'h55AA55AA || MEM_req !== 1'b0) begin errors++; $display("FAIL hold_im_done: rdy=%0b out=%h req=%0b expected 1 55aa55aa 0", IM_ready, IM_out, MEM_req); end
    tick();
    checks++; if (MEM_req !== 1'b1 || dbg_state !== S_DM || MEM_addr !== 32'h3000) begin errors++; $display("FAIL hold_dm_next: req=%0b state=%0d addr=%h expected 1 2 3000", MEM_req, dbg_state, MEM_addr); end
    MEM_ack = 1'b1; MEM_rdata = 32'h00000077;
    tick();
    MEM_ack = 1'b0; DM_en = 1'b0;
    checks++; if (DM_ready !== 1'b1 || DM_out !== 32'h77) begin errors++; $display("FAIL hold_dm_done: rdy=%0b out=%h expected 1 77", DM_ready, DM_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    DM_en = 1'b1; DM_write = 1'b0; DM_address = 32'h4000;
    tick();
    tick();
    checks++; if (dbg_state !== S_DM || MEM_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: state=%0d req=%0b expected 2 1", dbg_state, MEM_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; DM_en = 1'b0; MEM_ack = 1'b1; MEM_rdata = 32'h99999999;
    checks++; if (MEM_req !== 1'b0 || MEM_addr !== 32'h0 || DM_out !== 32'h0 || IM_out !== 32'h0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL rstmid_clear: req=%0b addr=%h dm_out=%h im_out=%h state=%0d expected all 0", MEM_req, MEM_addr, DM_out, IM_out, dbg_state); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (DM_ready !== 1'b0 || DM_out !== 32'h0 || MEM_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack%0d: rdy=%0b out=%h req=%0b expected 0 0 0", i, DM_ready, DM_out, MEM_req); end
    end
    MEM_ack = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_im_read();
    test_simultaneous();
    test_dm_store();
    test_starvation();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
